// File: rtl/mem_burst_ctrl_pkg.sv
`default_nettype none
// mem_burst_ctrl_pkg: FSM state encoding and default burst sizing shared by
// the burst controller and anything that needs to interpret its state.
package mem_burst_ctrl_pkg;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_LEN_W   = 5;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
`default_nettype none
// mem_burst_ctrl: single-master burst initiator for the word-addressed data
// memory; issues load/store bursts and streams load data back.
module mem_burst_ctrl
  import mem_burst_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrData,
  output logic              mem_wrMem,
  output logic              mem_rdMem,
  input  logic [DATA_W-1:0] mem_rdData
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                rd_valid_q;

  logic [LEN_W-1:0]    len_clamped;
  logic [ADDR_W-1:0]   beat_addr;
  logic                last_beat;

  assign len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  // Address adder wraps naturally at 2^ADDR_W; the memory only decodes the low bits.
  assign beat_addr   = base_q + ADDR_W'(cnt_q);
  assign last_beat   = (cnt_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          base_d = cmd_addr;
          len_d  = len_clamped;
          cnt_d  = '0;
          if (len_clamped == '0) begin
            state_d = ST_FIN;
          end else if (cmd_write) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (wd_valid) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_beat) state_d = ST_FIN;
        end
      end
      ST_RD: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (last_beat) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      // Memory read data is registered, so load data is valid one cycle after the strobe.
      rd_valid_q <= mem_rdMem;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign wd_ready   = (state_q == ST_WR);
  assign done       = (state_q == ST_FIN);
  assign mem_wrMem  = (state_q == ST_WR) && wd_valid;
  assign mem_rdMem  = (state_q == ST_RD);
  assign mem_wrData = (state_q == ST_WR) ? wd_data : '0;
  assign mem_addr   = ((state_q == ST_WR) || (state_q == ST_RD)) ? beat_addr : '0;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = mem_rdData;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
`default_nettype none
// tb_mem_burst_ctrl: directed self-checking bench with a 1024-word registered memory model.
module tb_mem_burst_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wd_valid, wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic              rd_valid, done;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wrData, mem_rdData;
  logic              mem_wrMem, mem_rdMem;

  mem_burst_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .MAX_LEN(16),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wrData(mem_wrData),
    .mem_wrMem (mem_wrMem),
    .mem_rdMem (mem_rdMem),
    .mem_rdData(mem_rdData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'd57;
      1:       return 32'd23;
      2:       return 32'd89;
      default: return 32'(1000 + i);
    endcase
  endfunction

  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_rdData <= '0;
    end else begin
      if (mem_wrMem) mem[mem_addr[9:0]] <= mem_wrData;
      if (mem_rdMem) mem_rdData <= mem[mem_addr[9:0]];
    end
  end

  int n_rd_str = 0;
  int n_wr_str = 0;
  int n_done   = 0;
  always @(negedge clk) begin
    if (mem_rdMem) n_rd_str++;
    if (mem_wrMem) n_wr_str++;
    if (done)      n_done++;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] ev [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at posedge+1 (or later) while IDLE; returns at posedge+1 of cycle 1.
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [4:0] len);
    check("cmd_ready_pre", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [31:0] addr, input logic [4:0] clen, input int n);
    int s0;
    s0 = n_rd_str;
    do_cmd(1'b0, addr, clen);
    for (int c = 1; c <= n + 1; c++) begin
      #1;
      if (c <= n) begin
        check({tag, " rdMem"}, mem_rdMem, 1);
        check({tag, " addr"}, mem_addr, addr + 32'(c - 1));
      end else begin
        check({tag, " rdMem_end"}, mem_rdMem, 0);
      end
      if (c >= 2) begin
        check({tag, " rd_valid"}, rd_valid, 1);
        check({tag, " rd_data"}, rd_data, ev[c-2]);
      end else begin
        check({tag, " rd_valid_first"}, rd_valid, 0);
      end
      check({tag, " done"}, done, (c == n + 1));
      @(posedge clk); #1;
    end
    #1;
    check({tag, " done_after"}, done, 0);
    check({tag, " rd_valid_after"}, rd_valid, 0);
    check({tag, " cmd_ready_after"}, cmd_ready, 1);
    check({tag, " strobes"}, 64'(n_rd_str - s0), 64'(n));
  endtask

  // Inserts `gap` idle wd_valid cycles after the first beat.
  task automatic run_store(input string tag, input logic [31:0] addr, input int n, input int gap);
    int b;
    int gaps_left;
    int s0;
    b = 0;
    gaps_left = gap;
    s0 = n_wr_str;
    do_cmd(1'b1, addr, 5'(n));
    for (int cyc = 0; cyc < n + gap; cyc++) begin
      if (b == 1 && gaps_left > 0) begin
        wd_valid = 1'b0;
        wd_data  = 32'hDEAD_BEEF;
        gaps_left--;
      end else begin
        wd_valid = 1'b1;
        wd_data  = ev[b];
      end
      #1;
      check({tag, " wd_ready"}, wd_ready, 1);
      check({tag, " wrMem"}, mem_wrMem, wd_valid);
      if (wd_valid) begin
        check({tag, " addr"}, mem_addr, addr + 32'(b));
        check({tag, " wrData"}, mem_wrData, ev[b]);
        b++;
      end
      @(posedge clk); #1;
    end
    wd_valid = 1'b0;
    #1;
    check({tag, " done"}, done, 1);
    check({tag, " wrMem_fin"}, mem_wrMem, 0);
    check({tag, " wd_ready_fin"}, wd_ready, 0);
    @(posedge clk); #2;
    check({tag, " done_after"}, done, 0);
    check({tag, " cmd_ready_after"}, cmd_ready, 1);
    check({tag, " strobes"}, 64'(n_wr_str - s0), 64'(n));
  endtask

  int s_rd, s_wr, s_done;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wd_valid  = 1'b0;
    wd_data   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst rd_valid", rd_valid, 0);
    check("rst done", done, 0);
    check("rst wd_ready", wd_ready, 0);
    check("rst rdMem", mem_rdMem, 0);
    check("rst wrMem", mem_wrMem, 0);
    check("rst addr", mem_addr, 0);
    check("rst wrData", mem_wrData, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel cmd_ready", cmd_ready, 1);

    ev[0] = 32'd57; ev[1] = 32'd23; ev[2] = 32'd89;
    run_load("ld0", 32'd0, 5'd3, 3);

    ev[0] = 32'd5; ev[1] = 32'd7;
    run_store("st10", 32'd10, 2, 2);
    run_load("ld10", 32'd10, 5'd2, 2);

    // Zero-length command, with stray store data offered in IDLE.
    wd_valid = 1'b1;
    wd_data  = 32'd99;
    #1;
    check("idle wrMem", mem_wrMem, 0);
    check("idle wd_ready", wd_ready, 0);
    wd_valid = 1'b0;
    s_rd = n_rd_str;
    s_wr = n_wr_str;
    do_cmd(1'b1, 32'd5, 5'd0);
    #1;
    check("len0 done", done, 1);
    check("len0 wrMem", mem_wrMem, 0);
    check("len0 rdMem", mem_rdMem, 0);
    check("len0 cmd_ready", cmd_ready, 0);
    @(posedge clk); #2;
    check("len0 done_after", done, 0);
    check("len0 cmd_ready_after", cmd_ready, 1);
    check("len0 strobes", 64'((n_rd_str - s_rd) + (n_wr_str - s_wr)), 0);

    // Oversized length clamps to 16 words.
    for (int i = 0; i < 16; i++) ev[i] = 32'(1100 + i);
    run_load("clamp", 32'd100, 5'd31, 16);

    ev[0] = 32'd1; ev[1] = 32'd2;
    run_store("wrap", 32'd1023, 2, 0);
    ev[0] = 32'd2;
    run_load("wrap_ld", 32'd0, 5'd1, 1);

    // cmd_valid held through a len-4 load; the second command waits for IDLE.
    ev[0] = 32'd23; ev[1] = 32'd89; ev[2] = 32'd1003; ev[3] = 32'd1004;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'd1;
    cmd_len   = 5'd4;
    @(posedge clk); #1;
    cmd_addr = 32'd2;
    cmd_len  = 5'd1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      check("hold cmd_ready", cmd_ready, 0);
      check("hold done", done, (c == 5));
      if (c >= 2) check("hold rd_data", rd_data, ev[c-2]);
      @(posedge clk); #1;
    end
    #1;
    check("hold cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #1;
    check("hold2 rdMem", mem_rdMem, 1);
    check("hold2 addr", mem_addr, 2);
    @(posedge clk); #2;
    check("hold2 rd_valid", rd_valid, 1);
    check("hold2 rd_data", rd_data, 89);
    check("hold2 done", done, 1);
    @(posedge clk); #2;
    check("hold2 idle", cmd_ready, 1);
    check("hold2 done_after", done, 0);

    // Reset asserted in the second cycle of a len-5 load.
    s_rd   = n_rd_str;
    s_done = n_done;
    do_cmd(1'b0, 32'd0, 5'd5);
    @(posedge clk); #1;
    check("abort rdMem_pre", mem_rdMem, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort rdMem", mem_rdMem, 0);
    check("abort rd_valid", rd_valid, 0);
    check("abort done", done, 0);
    check("abort addr", mem_addr, 0);
    check("abort cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      check("post rd_valid", rd_valid, 0);
      check("post done", done, 0);
      check("post rdMem", mem_rdMem, 0);
      check("post cmd_ready", cmd_ready, 1);
    end
    check("abort strobes", 64'(n_rd_str - s_rd), 1);
    check("abort no_done", 64'(n_done - s_done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
